// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall control block: FSM encoding and default sizing.
package hazard_stall_unit_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         DEF_CNT_W   = 16;
    localparam int         DEF_TIMEOUT = 64;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/bubble control for the 5-stage pipeline: load-use, taken branch and
// multi-cycle data-memory access, with a memory timeout watchdog and stall counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IDRegRs_i,
    input  logic [4:0]       IDRegRt_i,
    input  logic             IDUsesRt_i,
    input  logic             IDBranchTaken_i,
    input  logic             EXMemRead_i,
    input  logic [4:0]       EXRegRt_i,
    input  logic             MEMAccess_i,
    input  logic             MemAck_i,
    output logic             MemReq_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXWrite_o,
    output logic             IDEXBubble_o,
    output logic             EXMEMWrite_o,
    output logic             MEMWBBubble_o,
    output logic             MemErr_o,
    output logic [CNT_W-1:0] StallCount_o,
    output state_t           DbgState_o
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state_q;
    logic          err_q;
    logic          freeze;
    logic          loaduse;
    logic          enter_wait;
    logic          in_wait;
    logic [TW-1:0] wait_cnt;

    always_comb begin
        in_wait    = (state_q == MEM_WAIT);
        enter_wait = !in_wait && MEMAccess_i && !MemAck_i;
        freeze     = in_wait ? !MemAck_i : enter_wait;
        loaduse    = EXMemRead_i && (EXRegRt_i != REG_ZERO) &&
                     ((EXRegRt_i == IDRegRs_i) || (IDUsesRt_i && (EXRegRt_i == IDRegRt_i)));
    end

    // Handshake: MemReq_o rises with MEMAccess_i and is held until the cycle MemAck_i
    // is seen high; the pipeline advances on the edge that samples the ack.
    always_comb begin
        MemReq_o      = 1'b0;
        PCWrite_o     = 1'b0;
        IFIDWrite_o   = 1'b0;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b0;
        IDEXBubble_o  = 1'b0;
        EXMEMWrite_o  = 1'b0;
        MEMWBBubble_o = 1'b0;
        if (!rst_i) begin
            MemReq_o = in_wait || MEMAccess_i;
            if (freeze) begin
                MEMWBBubble_o = 1'b1;
            end else if (loaduse) begin
                IDEXWrite_o  = 1'b1;
                IDEXBubble_o = 1'b1;
                EXMEMWrite_o = 1'b1;
            end else begin
                PCWrite_o    = 1'b1;
                IFIDWrite_o  = 1'b1;
                IFIDFlush_o  = IDBranchTaken_i;
                IDEXWrite_o  = 1'b1;
                EXMEMWrite_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (enter_wait) state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (MemAck_i) state_q <= RUN;
                    // wait_cnt counts MEM_WAIT cycles already elapsed; this one makes TIMEOUT
                    if (wait_cnt == T_LAST) err_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (freeze || loaduse),
        .count (StallCount_o)
    );

    sat_counter #(.W(TW)) u_wait_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (enter_wait),
        .inc   (in_wait),
        .count (wait_cnt)
    );

    assign MemErr_o   = err_q;
    assign DbgState_o = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, multi-cycle sequences and
// randomized traffic against a behavioural model.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    localparam int CNT_W     = 6;
    localparam int TIMEOUT   = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       exmr;
        logic [4:0] exrt;
        logic       acc;
        logic       ack;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_br, ex_mem_read, mem_access, mem_ack;
    logic             mem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic             exmem_write, memwb_bubble, mem_err;
    logic [CNT_W-1:0] stall_count;
    state_t           dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    bit         m_outstanding = 0;
    int         m_wait_cycles = 0;
    bit         m_err = 0;
    int         m_stalls = 0;
    logic [7:0] last_flags;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .IDRegRs_i       (id_rs),
        .IDRegRt_i       (id_rt),
        .IDUsesRt_i      (id_uses_rt),
        .IDBranchTaken_i (id_br),
        .EXMemRead_i     (ex_mem_read),
        .EXRegRt_i       (ex_rt),
        .MEMAccess_i     (mem_access),
        .MemAck_i        (mem_ack),
        .MemReq_o        (mem_req),
        .PCWrite_o       (pc_write),
        .IFIDWrite_o     (ifid_write),
        .IFIDFlush_o     (ifid_flush),
        .IDEXWrite_o     (idex_write),
        .IDEXBubble_o    (idex_bubble),
        .EXMEMWrite_o    (exmem_write),
        .MEMWBBubble_o   (memwb_bubble),
        .MemErr_o        (mem_err),
        .StallCount_o    (stall_count),
        .DbgState_o      (dbg_state)
    );

    function automatic in_t mk(input int rs, input int rt, input bit u, input bit br,
                               input bit exmr, input int exrt, input bit acc, input bit ack);
        in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u; v.br = br;
        v.exmr = exmr; v.exrt = 5'(exrt); v.acc = acc; v.ack = ack;
        return v;
    endfunction

    function automatic logic [7:0] act_flags();
        return {mem_req, pc_write, ifid_write, ifid_flush,
                idex_write, idex_bubble, exmem_write, memwb_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_br = v.br;
        ex_mem_read = v.exmr; ex_rt = v.exrt; mem_access = v.acc; mem_ack = v.ack;
    endtask

    // Reference rules: a memory access is outstanding until acked; the pipeline freezes
    // while it is outstanding and un-acked, otherwise load-use, then branch, take effect.
    function automatic bit m_freeze(input in_t v);
        return (m_outstanding || v.acc) && !v.ack;
    endfunction

    function automatic bit m_loaduse(input in_t v);
        if (!v.exmr || v.exrt == 5'd0) return 0;
        return (v.exrt == v.rs) || (v.uses_rt && v.exrt == v.rt);
    endfunction

    function automatic logic [7:0] m_flags(input in_t v);
        logic req;
        req = m_outstanding || v.acc;
        if (m_freeze(v))       return {req, 7'b000_0001};
        else if (m_loaduse(v)) return {req, 7'b000_1110};
        else if (v.br)         return {req, 7'b111_1010};
        else                   return {req, 7'b110_1010};
    endfunction

    task automatic m_advance(input in_t v);
        if (m_freeze(v) || m_loaduse(v)) begin
            if (m_stalls < STALL_MAX) m_stalls++;
        end
        if (m_outstanding) begin
            m_wait_cycles++;
            if (m_wait_cycles >= TIMEOUT) m_err = 1;
            if (v.ack) m_outstanding = 0;
        end else if (v.acc && !v.ack) begin
            m_outstanding = 1;
            m_wait_cycles = 0;
        end
    endtask

    task automatic step(input in_t v, input string name);
        @(negedge clk);
        drive(v);
        #2;
        last_flags = act_flags();
        check({name, " flags"}, 32'(last_flags), 32'(m_flags(v)));
        check({name, " stall"}, 32'(stall_count), 32'(m_stalls));
        check({name, " err"}, 32'(mem_err), 32'(m_err));
        m_advance(v);
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("reset flags", 32'(act_flags()), 32'h0);
        check("reset stall", 32'(stall_count), 32'h0);
        check("reset err", 32'(mem_err), 32'h0);
        m_outstanding = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        in_t idle, lu, wait_na, wait_ack;
        int  s0, req_cnt, frz_cnt;

        tbl[0]  = '{mk(2, 0, 0, 0, 1, 2, 0, 0), 8'b0000_1110};
        tbl[1]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0), 8'b0110_1010};
        tbl[2]  = '{mk(5, 2, 0, 0, 1, 2, 0, 0), 8'b0110_1010};
        tbl[3]  = '{mk(5, 2, 1, 0, 1, 2, 0, 0), 8'b0000_1110};
        tbl[4]  = '{mk(1, 3, 1, 1, 0, 1, 0, 0), 8'b0111_1010};
        tbl[5]  = '{mk(4, 0, 0, 1, 1, 4, 0, 0), 8'b0000_1110};
        tbl[6]  = '{mk(1, 1, 0, 0, 0, 0, 1, 1), 8'b1110_1010};
        tbl[7]  = '{mk(2, 0, 0, 0, 0, 2, 0, 0), 8'b0110_1010};
        tbl[8]  = '{mk(3, 3, 1, 0, 0, 0, 0, 1), 8'b0110_1010};
        tbl[9]  = '{mk(6, 0, 0, 0, 1, 6, 1, 1), 8'b1000_1110};
        tbl[10] = '{mk(3, 7, 1, 0, 1, 7, 0, 0), 8'b0000_1110};
        tbl[11] = '{mk(0, 0, 0, 1, 0, 0, 1, 1), 8'b1111_1010};

        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0);
        lu       = mk(2, 0, 0, 0, 1, 2, 0, 0);
        wait_na  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        wait_ack = mk(0, 0, 0, 0, 0, 0, 1, 1);

        drive(idle);
        #3;
        check("por flags", 32'(act_flags()), 32'h0);
        check("por stall", 32'(stall_count), 32'h0);
        check("por err", 32'(mem_err), 32'h0);
        check("por state", 32'(dbg_state), 32'(RUN));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].in, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), 32'(last_flags), 32'(tbl[i].exp));
        end

        // Load-use costs exactly one stall; the dependent instruction then proceeds.
        s0 = m_stalls;
        step(lu, "lu");
        step(mk(2, 0, 0, 0, 0, 9, 0, 0), "lu_after");
        check("lu after flags", 32'(last_flags), 32'b0110_1010);
        @(posedge clk); #1;
        check("lu stall delta", 32'(stall_count), 32'(s0 + 1));

        // Memory access acked three cycles after it is presented.
        s0 = m_stalls; req_cnt = 0; frz_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step((k == 3) ? wait_ack : wait_na, $sformatf("mw%0d", k));
            req_cnt += int'(last_flags[7]);
            frz_cnt += int'(last_flags[0] && last_flags[6:1] == 6'b000000);
        end
        check("mw req cycles", 32'(req_cnt), 32'd4);
        check("mw freeze cycles", 32'(frz_cnt), 32'd3);
        @(posedge clk); #1;
        check("mw state", 32'(dbg_state), 32'(RUN));
        check("mw stall delta", 32'(stall_count), 32'(s0 + 3));

        step(wait_ack, "same_cycle_ack");
        check("same ack no freeze", 32'(last_flags[0]), 32'd0);

        // Timeout: error appears after TIMEOUT waiting cycles and survives the ack.
        do_reset();
        step(wait_na, "to_enter");
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(wait_na, $sformatf("to_wait%0d", k));
            @(posedge clk); #1;
            check($sformatf("to err after %0d", k), 32'(mem_err), (k >= TIMEOUT) ? 32'd1 : 32'd0);
        end
        step(wait_ack, "to_ack");
        step(idle, "to_idle");
        @(posedge clk); #1;
        check("to err sticky", 32'(mem_err), 32'd1);
        do_reset();
        check("to err cleared", 32'(mem_err), 32'd0);

        // Reset arriving mid-wait drops the request without a clock edge.
        step(wait_na, "ar_enter");
        step(wait_na, "ar_wait");
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("ar memreq", 32'(mem_req), 32'd0);
        check("ar flags", 32'(act_flags()), 32'h0);
        m_outstanding = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0;
        drive(idle);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ar state", 32'(dbg_state), 32'(RUN));
        check("ar stall", 32'(stall_count), 32'd0);

        // Saturation of the stall counter.
        for (int k = 0; k < STALL_MAX + 8; k++) step(lu, "sat");
        @(posedge clk); #1;
        check("sat value", 32'(stall_count), 32'(STALL_MAX));

        do_reset();
        for (int k = 0; k < 1500; k++) begin
            in_t v;
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 2) == 0));
            step(v, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side counterpart to the pipeline forwarding logic in the 5-stage MIPS core.
- Handles the hazards that forwarding cannot cover: load-use, branch-taken flush, and multi-cycle data-memory access.
- Drives write-enables, flushes and bubbles for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Owns the data-memory request/ack handshake, a timeout watchdog and a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle performance counter.
- TIMEOUT, 64, cycles in MEM_WAIT before MemErr_o is raised (must be ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- IDRegRs_i  in  5  rs of the instruction in ID.
- IDRegRt_i  in  5  rt of the instruction in ID.
- IDUsesRt_i  in  1  ID instruction reads rt (R-type, store, beq).
- IDBranchTaken_i  in  1  branch in ID resolved taken.
- EXMemRead_i  in  1  instruction in EX is a load.
- EXRegRt_i  in  5  load destination in EX.
- MEMAccess_i  in  1  instruction in MEM is a load or store.
- MemAck_i  in  1  data memory completes the access this cycle.
- MemReq_o  out  1  data-memory request.
- PCWrite_o  out  1  PC write enable.
- IFIDWrite_o  out  1  IF/ID write enable.
- IFIDFlush_o  out  1  IF/ID load NOP.
- IDEXWrite_o  out  1  ID/EX write enable.
- IDEXBubble_o  out  1  ID/EX load control-zero bubble.
- EXMEMWrite_o  out  1  EX/MEM write enable.
- MEMWBBubble_o  out  1  MEM/WB load bubble.
- MemErr_o  out  1  sticky memory timeout error.
- StallCount_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_i high, async):
  - State RUN, StallCount_o=0, MemErr_o=0, timeout counter=0.
  - While rst_i is high, all write-enables are 0 and MemReq_o, flush and bubble outputs are 0.
- FSM states: RUN, MEM_WAIT.
- freeze = MEMAccess_i & ~MemAck_i in RUN; freeze = ~MemAck_i in MEM_WAIT.
- RUN → MEM_WAIT when MEMAccess_i & ~MemAck_i.
- MEM_WAIT → RUN on MemAck_i. Pipeline advances on that same edge, so a 1-cycle ack costs 0 stalls.
- MemReq_o = MEMAccess_i in RUN; 1 in MEM_WAIT. Held stable until ack.
- loaduse = EXMemRead_i & EXRegRt_i!=0 & (EXRegRt_i==IDRegRs_i | (IDUsesRt_i & EXRegRt_i==IDRegRt_i)).
- Output priority, evaluated combinationally each cycle:
  - freeze: PCWrite, IFIDWrite, IDEXWrite and EXMEMWrite = 0; MEMWBBubble=1; no flush and no ID/EX bubble.
  - else loaduse: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0. The branch is re-evaluated next cycle.
  - else IDBranchTaken_i: IFIDFlush=1; all enables 1.
  - else all enables 1; flush and bubbles 0.
- Load-use inserts exactly one bubble. The next cycle the load is in MEM, so forwarding covers the dependency.
- StallCount_o:
  - +1 on every cycle with freeze or loaduse (not on flush).
  - Saturates at all-ones and does not wrap.
- Timeout:
  - Counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - Reaching TIMEOUT sets MemErr_o (sticky until reset).
  - The FSM keeps waiting for ack.
- Reset mid-MEM_WAIT returns to RUN immediately and MemReq_o drops asynchronously.
- A MemAck_i arriving while MEMAccess_i=0 in RUN is ignored.

Decomposition:
- Shared package: state encoding (RUN, MEM_WAIT), REG_ZERO=5'd0, default CNT_W/TIMEOUT constants.
- One sub-module: sat_counter (parameterised width, inc, clr, saturating). Instantiated for StallCount_o and the timeout counter.

Test Plan:
- lw $2 in EX (EXMemRead=1, EXRegRt=2), ID rs=2:
  - Expect for exactly 1 cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1, StallCount 0→1.
  - Repeat with EXRegRt=0: no stall.
- IDUsesRt=0, IDRegRt=2, EXRegRt=2, IDRegRs=5: no stall. Set IDUsesRt=1: stall asserted.
- IDBranchTaken=1 with no hazard: IFIDFlush=1, PCWrite=1. Branch plus loaduse in the same cycle: IFIDFlush=0, IDEXBubble=1.
- MEMAccess=1 with MemAck 3 cycles later:
  - MemReq=1 for 4 cycles; freeze for 3 cycles with MEMWBBubble=1 and all enables 0.
  - Return to RUN on the ack edge; StallCount +3.
  - Same-cycle ack: no freeze.
- TIMEOUT=4 with no ack:
  - MemErr=1 after 4 MEM_WAIT cycles and stays 1 after a later ack.
  - Cleared only by rst_i.
- Assert rst_i asynchronously mid-MEM_WAIT: MemReq_o=0 immediately; after release, state RUN and StallCount=0. Counter preload near max verifies saturation at all-ones.
